// File: rtl/ddr3_pkg.sv
// Shared constants for the DDR3 app-interface blocks: command codes, burst sizing, watchdog limit.
package ddr3_pkg;

  localparam logic [2:0]  CMD_WR     = 3'b000;
  localparam logic [2:0]  CMD_RD     = 3'b001;
  localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

  // "8" is BL8 (two app beats per read); anything else is treated as BC4 (one beat)
  function automatic int burst_beats(input logic [7:0] mode);
    return (mode == "8") ? 2 : 1;
  endfunction

endpackage

// File: rtl/ddr3_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; head entry is always on pop_data.
module ddr3_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_rd_return.sv
// DDR3 read-return path: assembles returned beats into bursts and pairs them in order with issued read tags.
// Define DDR3_RD_TIMEOUT_EN to add a watchdog that flags reads whose data never comes back.
module ddr3_rd_return
  import ddr3_pkg::*;
#(
  parameter int         APP_DATA_WIDTH = 64,
  parameter int         ADDR_W         = 16,
  parameter logic [7:0] BURST_MODE     = "4",
  parameter int         DEPTH          = 8,
  localparam int        BEATS          = burst_beats(BURST_MODE),
  localparam int        CW             = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            init_calib_complete,
  input  logic                            rd_issue,
  input  logic [ADDR_W-1:0]               rd_issue_addr,
  input  logic                            app_rd_data_valid,
  input  logic                            app_rd_data_end,
  input  logic [APP_DATA_WIDTH-1:0]       app_rd_data,
  output logic                            rd_credit,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [BEATS*APP_DATA_WIDTH-1:0] out_data,
  output logic [ADDR_W-1:0]               out_addr,
  output logic [CW-1:0]                   outstanding,
  output logic                            error,
  output logic                            error_flag
);

  localparam int         BURST_W   = BEATS * APP_DATA_WIDTH;
  localparam int         ENTRY_W   = ADDR_W + BURST_W;
  localparam logic [0:0] LAST_BEAT = 1'(BEATS - 1);

  logic [ADDR_W-1:0]         tag_head;
  logic                      tag_full;
  logic                      tag_empty;
  logic [CW-1:0]             tag_count;
  logic [ENTRY_W-1:0]        out_entry;
  logic                      out_full;
  logic                      out_empty;
  logic [CW-1:0]             out_count;
  logic                      out_pop;
  logic [0:0]                beat_cnt;
  logic [APP_DATA_WIDTH-1:0] beat_buf [BEATS];
  logic [BURST_W-1:0]        burst_data;
  logic [ADDR_W-1:0]         burst_tag;
  logic                      at_last;
  logic                      burst_done;
  logic                      early_end;
  logic                      missing_end;
  logic                      orphan;
  logic                      tag_overflow;
  logic                      out_overflow;
  logic                      wdog_hit;
  logic                      err_event;
  logic                      calib_q;
  logic [CW:0]               inflight;

  assign at_last     = (beat_cnt == LAST_BEAT);
  assign burst_done  = app_rd_data_valid & at_last;
  assign early_end   = app_rd_data_valid & ~at_last & app_rd_data_end;
  assign missing_end = burst_done & ~app_rd_data_end;
  assign orphan      = burst_done & tag_empty;
  assign burst_tag   = orphan ? '0 : tag_head;
  assign out_pop     = out_valid & out_ready;
  assign tag_overflow = rd_issue & tag_full & ~burst_done;
  assign out_overflow = burst_done & out_full & ~out_pop;

  ddr3_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_issue),
    .push_data (rd_issue_addr),
    .pop       (burst_done),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  ddr3_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (burst_done),
    .push_data ({burst_tag, burst_data}),
    .pop       (out_pop),
    .pop_data  (out_entry),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  assign out_valid   = ~out_empty;
  assign out_addr    = out_entry[ENTRY_W-1 -: ADDR_W];
  assign out_data    = out_entry[BURST_W-1:0];
  assign outstanding = tag_count;

  // the final beat goes straight into its slot so the burst is pushed on the cycle it arrives
  always_comb begin
    burst_data = '0;
    for (int i = 0; i < BEATS; i++)
      burst_data[i*APP_DATA_WIDTH +: APP_DATA_WIDTH] = (beat_cnt == 1'(i)) ? app_rd_data : beat_buf[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      for (int i = 0; i < BEATS; i++) beat_buf[i] <= '0;
    end else if (app_rd_data_valid) begin
      if (at_last || app_rd_data_end) begin
        beat_cnt <= '0;
      end else begin
        beat_buf[beat_cnt] <= app_rd_data;
        beat_cnt           <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef DDR3_RD_TIMEOUT_EN
  logic [15:0] wdog;

  assign wdog_hit = (tag_count != '0) & ~app_rd_data_valid & (wdog == WDOG_LIMIT - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (tag_count == '0 || app_rd_data_valid) begin
      wdog <= '0;
    end else if (wdog != WDOG_LIMIT) begin
      wdog <= wdog + 16'd1;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  assign err_event = tag_overflow | early_end | missing_end | orphan | out_overflow | wdog_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error      <= 1'b0;
      error_flag <= 1'b0;
      calib_q    <= 1'b0;
    end else begin
      error      <= error | err_event;
      error_flag <= err_event;
      calib_q    <= init_calib_complete;
    end
  end

  // credit comes only from registers so the issuer sees no combinational path through this block
  assign inflight  = {1'b0, tag_count} + {1'b0, out_count};
  assign rd_credit = calib_q & (inflight < (CW+1)'(DEPTH));

endmodule

// File: tb/tb_ddr3_rd_return.sv
// Scoreboard bench for ddr3_rd_return: a BL8 and a BC4 instance checked against queue-based models.
module tb_ddr3_rd_return;

  localparam int W     = 64;
  localparam int AW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic calib = 1'b0;
  always #5 clk = ~clk;

  logic          iss8 = 1'b0, v8 = 1'b0, e8 = 1'b0, rdy8 = 1'b0;
  logic [AW-1:0] issa8 = '0;
  logic [W-1:0]  d8 = '0;
  logic          cred8, ov8, err8, ef8;
  logic [2*W-1:0] od8;
  logic [AW-1:0] oa8;
  logic [CW-1:0] outst8;

  logic          iss4 = 1'b0, v4 = 1'b0, e4 = 1'b0, rdy4 = 1'b0;
  logic [AW-1:0] issa4 = '0;
  logic [W-1:0]  d4 = '0;
  logic          cred4, ov4, err4, ef4;
  logic [W-1:0]  od4;
  logic [AW-1:0] oa4;
  logic [CW-1:0] outst4;

  ddr3_rd_return #(.APP_DATA_WIDTH(W), .ADDR_W(AW), .BURST_MODE("8"), .DEPTH(DEPTH)) u_dut8 (
    .clk(clk), .rst(rst), .init_calib_complete(calib),
    .rd_issue(iss8), .rd_issue_addr(issa8),
    .app_rd_data_valid(v8), .app_rd_data_end(e8), .app_rd_data(d8),
    .rd_credit(cred8), .out_valid(ov8), .out_ready(rdy8), .out_data(od8), .out_addr(oa8),
    .outstanding(outst8), .error(err8), .error_flag(ef8)
  );

  ddr3_rd_return #(.APP_DATA_WIDTH(W), .ADDR_W(AW), .BURST_MODE("4"), .DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .rst(rst), .init_calib_complete(calib),
    .rd_issue(iss4), .rd_issue_addr(issa4),
    .app_rd_data_valid(v4), .app_rd_data_end(e4), .app_rd_data(d4),
    .rd_credit(cred4), .out_valid(ov4), .out_ready(rdy4), .out_data(od4), .out_addr(oa4),
    .outstanding(outst4), .error(err4), .error_flag(ef4)
  );

  // reference model: issued tags, beats of the burst in progress, expected deliveries
  logic [AW-1:0]      tagq8[$];
  logic [AW-1:0]      tagq4[$];
  logic [W-1:0]       pend8[$];
  logic [AW+2*W-1:0]  exp8_q[$];
  logic [AW+W-1:0]    exp4_q[$];
  int ev8 = 0, ev4 = 0, flag8 = 0, flag4 = 0;
  int tests = 0, fails = 0;

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ov8) begin
      if (exp8_q.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL sb8_extra: got %0h, expected no entry", {oa8, od8});
      end else if (rdy8) checkOutput("sb8_pop", {oa8, od8}, exp8_q.pop_front());
      else checkOutput("sb8_hold", {oa8, od8}, exp8_q[0]);
    end
    if (!rst && ov4) begin
      if (exp4_q.size() == 0) begin
        tests++; fails++;
        $display("[TB] FAIL sb4_extra: got %0h, expected no entry", {oa4, od4});
      end else if (rdy4) checkOutput("sb4_pop", {oa4, od4}, exp4_q.pop_front());
      else checkOutput("sb4_hold", {oa4, od4}, exp4_q[0]);
    end
    if (ef8) flag8++;
    if (ef4) flag4++;
  end

  // one clock of BL8 stimulus; the model applies burst completion before the new issue
  task automatic applyStimulus8(input logic iss, input logic [AW-1:0] addr, input logic v,
                                input logic [W-1:0] d, input logic e, input bit use_cred = 0);
    bit ev = 1'b0;
    logic [AW-1:0] tag;
    @(posedge clk); #1;
    if (use_cred && !cred8) iss = 1'b0;
    iss8 = iss; issa8 = addr; v8 = v; d8 = d; e8 = e;
    iss4 = 1'b0; v4 = 1'b0; e4 = 1'b0;
    if (v) begin
      pend8.push_back(d);
      if (pend8.size() == 2) begin
        if (!e) ev = 1'b1;
        if (tagq8.size() > 0) tag = tagq8.pop_front();
        else begin tag = '0; ev = 1'b1; end
        if (exp8_q.size() < DEPTH || rdy8) exp8_q.push_back({tag, pend8[1], pend8[0]});
        else ev = 1'b1;
        pend8.delete();
      end else if (e) begin
        ev = 1'b1;
        pend8.delete();
      end
    end
    if (iss) begin
      if (tagq8.size() < DEPTH) tagq8.push_back(addr);
      else ev = 1'b1;
    end
    if (ev) ev8++;
  endtask

  task automatic applyStimulus4(input logic iss, input logic [AW-1:0] addr, input logic v,
                                input logic [W-1:0] d, input logic e, input bit use_cred = 0);
    bit ev = 1'b0;
    logic [AW-1:0] tag;
    @(posedge clk); #1;
    if (use_cred && !cred4) iss = 1'b0;
    iss4 = iss; issa4 = addr; v4 = v; d4 = d; e4 = e;
    iss8 = 1'b0; v8 = 1'b0; e8 = 1'b0;
    if (v) begin
      if (!e) ev = 1'b1;
      if (tagq4.size() > 0) tag = tagq4.pop_front();
      else begin tag = '0; ev = 1'b1; end
      if (exp4_q.size() < DEPTH || rdy4) exp4_q.push_back({tag, d});
      else ev = 1'b1;
    end
    if (iss) begin
      if (tagq4.size() < DEPTH) tagq4.push_back(addr);
      else ev = 1'b1;
    end
    if (ev) ev4++;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus8(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic checkErrors();
    idle(2);
    checkOutput("err8", err8, ev8 != 0);
    checkOutput("flag8_count", flag8, ev8);
    checkOutput("err4", err4, ev4 != 0);
    checkOutput("flag4_count", flag4, ev4);
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    rst = 1'b1;
    iss8 = 1'b0; v8 = 1'b0; e8 = 1'b0; rdy8 = 1'b0;
    iss4 = 1'b0; v4 = 1'b0; e4 = 1'b0; rdy4 = 1'b0;
    tagq8.delete(); tagq4.delete(); pend8.delete(); exp8_q.delete(); exp4_q.delete();
    ev8 = 0; ev4 = 0; flag8 = 0; flag4 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_state8", {cred8, ov8, od8, oa8, outst8, err8, ef8}, '0);
    checkOutput("rst_state4", {cred4, ov4, od4, oa4, outst4, err4, ef4}, '0);
    idle(1);
    checkOutput("rst_credit8", cred8, calib);
    checkOutput("rst_credit4", cred4, calib);
  endtask

  initial begin
    logic [W-1:0] a, b;

    applyReset();
    calib = 1'b1;
    idle(2);
    checkOutput("calib_credit8", cred8, 1'b1);
    checkOutput("calib_credit4", cred4, 1'b1);

    // BC4: single beat delivered one cycle after it arrives
    rdy4 = 1'b1;
    applyStimulus4(1'b1, 16'h0010, 1'b0, '0, 1'b0);
    applyStimulus4(1'b0, '0, 1'b1, 64'h1505_5a21_25b5_fa1a, 1'b1);
    idle(1);
    checkOutput("bc4_valid", ov4, 1'b1);
    checkOutput("bc4_addr", oa4, 16'h0010);
    checkOutput("bc4_data", od4, 64'h1505_5a21_25b5_fa1a);
    checkErrors();

    // BC4: missing end still delivers; then a beat with no tag comes out with tag 0
    applyStimulus4(1'b1, 16'h0033, 1'b0, '0, 1'b0);
    applyStimulus4(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b0);
    idle(3);
    applyStimulus4(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b1);
    idle(3);
    checkOutput("bc4_drain", exp4_q.size(), 0);
    checkErrors();

    // BL8: two beats assembled with beat0 in the low half
    applyReset();
    rdy8 = 1'b1;
    applyStimulus8(1'b1, 16'h0020, 1'b0, '0, 1'b0);
    applyStimulus8(1'b0, '0, 1'b1, 64'h1000_0100_2180_f290, 1'b0);
    applyStimulus8(1'b0, '0, 1'b1, 64'h3000_0300_429e_d4a1, 1'b1);
    idle(1);
    checkOutput("bl8_valid", ov8, 1'b1);
    checkOutput("bl8_addr", oa8, 16'h0020);
    checkOutput("bl8_data", od8, {64'h3000_0300_429e_d4a1, 64'h1000_0100_2180_f290});
    checkErrors();

    // fill all credit, overflow once, then return data and drain in issue order
    rdy8 = 1'b0;
    for (int i = 0; i < DEPTH; i++) applyStimulus8(1'b1, AW'(16'h0100 + i), 1'b0, '0, 1'b0);
    checkOutput("credit_at7", {cred8, outst8}, {1'b1, 4'd7});
    applyStimulus8(1'b1, 16'h01FF, 1'b0, '0, 1'b0);
    checkOutput("credit_at8", {cred8, outst8}, {1'b0, 4'd8});
    checkErrors();
    for (int i = 0; i < DEPTH; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      applyStimulus8(1'b0, '0, 1'b1, a, 1'b0);
      applyStimulus8(1'b0, '0, 1'b1, b, 1'b1);
    end
    idle(1);
    checkOutput("credit_outfull", {cred8, outst8, ov8}, {1'b0, 4'd0, 1'b1});
    rdy8 = 1'b1;
    idle(12);
    checkOutput("bl8_drain", exp8_q.size(), 0);
    checkErrors();

    // BL8 orphan burst
    applyReset();
    rdy8 = 1'b1;
    applyStimulus8(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b0);
    applyStimulus8(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b1);
    idle(3);
    checkOutput("orphan8_drain", exp8_q.size(), 0);
    checkErrors();

    // BL8 early end discards the partial burst; the next burst is intact
    applyReset();
    rdy8 = 1'b1;
    applyStimulus8(1'b1, 16'h0055, 1'b0, '0, 1'b0);
    applyStimulus8(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b1);
    applyStimulus8(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b0);
    applyStimulus8(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b1);
    idle(3);
    checkOutput("early8_drain", exp8_q.size(), 0);
    checkErrors();

    // random traffic honouring credit on both instances
    applyReset();
    for (int n = 0; n < 300; n++) begin
      rdy8 = ($urandom_range(0, 3) != 0);
      applyStimulus8($urandom_range(0, 2) == 0, AW'($urandom), (tagq8.size() > 0) && ($urandom_range(0, 1) == 0),
                     {$urandom, $urandom}, pend8.size() == 1, 1'b1);
    end
    for (int n = 0; n < 300; n++) begin
      rdy4 = ($urandom_range(0, 3) != 0);
      applyStimulus4($urandom_range(0, 2) == 0, AW'($urandom), (tagq4.size() > 0) && ($urandom_range(0, 1) == 0),
                     {$urandom, $urandom}, 1'b1, 1'b1);
    end
    rdy8 = 1'b1; rdy4 = 1'b1;
    idle(12);
    checkOutput("rand8_drain", exp8_q.size(), 0);
    checkOutput("rand4_drain", exp4_q.size(), 0);
    checkErrors();

    // leave a burst half-delivered; the following reset must clear it
    applyStimulus8(1'b1, 16'h0AAA, 1'b0, '0, 1'b0);
    applyStimulus8(1'b1, 16'h0BBB, 1'b1, {$urandom, $urandom}, 1'b0);

    // watchdog: one read that never returns data
    applyReset();
    rdy8 = 1'b1;
    applyStimulus8(1'b1, 16'h0777, 1'b0, '0, 1'b0);
    idle(65000);
    checkOutput("wdog_quiet", {err8, flag8}, '0);
    for (int i = 0; i < 1000 && flag8 == 0; i++) idle(1);
`ifdef DDR3_RD_TIMEOUT_EN
    ev8++;
`endif
    checkErrors();
    applyStimulus8(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b0);
    applyStimulus8(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b1);
    idle(4);
    checkOutput("wdog_drain", exp8_q.size(), 0);
    checkErrors();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
